// File: rtl/cory_demux_route_pkg.sv
// Shared types and width helper for the cory_demux routing front end.
// The select width is derived from the demux output count R exactly as cory_demux does.
package cory_demux_route_pkg;

    typedef enum logic {
        SOP  = 1'b0,
        BODY = 1'b1
    } state_e;

    function automatic int unsigned sel_width(input int unsigned r);
        if (r <= 2)
            return 1;
        else if (r <= 4)
            return 2;
        else if (r <= 8)
            return 3;
        else
            return 4;
    endfunction

endpackage

// File: rtl/cory_demux_route_if.sv
// Packet input stream plus the forked data (z) and select (s) output streams.
// The slave modport is the router's view; master is the surrounding environment's view.
interface cory_demux_route_if #(
    parameter int unsigned N = 8,
    parameter int unsigned S = 1
);
    logic         a_v;
    logic [N-1:0] a_d;
    logic         a_l;
    logic         a_r;

    logic         z_v;
    logic [N-1:0] z_d;
    logic         z_r;

    logic         s_v;
    logic [S-1:0] s_d;
    logic         s_r;

    modport slave (
        input  a_v, a_d, a_l, z_r, s_r,
        output a_r, z_v, z_d, s_v, s_d
    );

    modport master (
        output a_v, a_d, a_l, z_r, s_r,
        input  a_r, z_v, z_d, s_v, s_d
    );
endinterface

// File: rtl/cory_demux_route_pipe.sv
// One-entry valid/data register with its own downstream ready.
// Drain and reload in the same cycle keeps valid high with the new contents.
module cory_pipe #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    input  logic         rdy_i,
    output logic         v_o,
    output logic [W-1:0] d_o
);
    logic         v_q, v_d;
    logic [W-1:0] d_q, d_d;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (load_i) begin
            v_d = 1'b1;
            d_d = d_i;
        end else if (rdy_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;
endmodule

// File: rtl/cory_demux_route.sv
// Latches a packet's destination from its first beat and forks every forwarded beat
// into independent data and select streams feeding cory_demux.
module cory_demux_route
    import cory_demux_route_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned R        = 2,
    parameter int unsigned DROP_HDR = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    cory_demux_route_if.slave        bus,
    output logic                     o_err,
    output logic [15:0]              o_pkt_cnt
);
    localparam int unsigned S    = sel_width(R);
    localparam bit          DROP = (DROP_HDR != 0);
    localparam logic [S-1:0] CLAMP = S'(R - 1);

    state_e       state_q, state_d;
    logic [S-1:0] dest_q, dest_d;
    logic         err_q, err_d;
    logic [15:0]  cnt_q, cnt_d;

    logic [S-1:0] raw_dest;
    logic         oor;
    logic [S-1:0] dest_new;
    logic [S-1:0] sel_now;
    logic         in_sop;
    logic         accept;
    logic         fwd;
    logic         pipes_free;

    assign in_sop   = (state_q == SOP);
    assign raw_dest = bus.a_d[S-1:0];
    assign oor      = (32'(raw_dest) >= R);
    assign dest_new = oor ? CLAMP : raw_dest;
    // The header beat's own select must use the fresh destination, not the stale latch.
    assign sel_now  = in_sop ? dest_new : dest_q;

    assign pipes_free = (!bus.z_v | bus.z_r) & (!bus.s_v | bus.s_r);
    // A dropped header never touches the pipes, so it needs no downstream space.
    assign bus.a_r    = (in_sop && DROP) ? 1'b1 : pipes_free;
    assign accept     = bus.a_v & bus.a_r;
    assign fwd        = accept & !(in_sop && DROP);

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (accept) begin
            if (in_sop) begin
                dest_d = dest_new;
                if (oor)
                    err_d = 1'b1;
            end
            if (bus.a_l) begin
                state_d = SOP;
                cnt_d   = cnt_q + 16'd1;
            end else begin
                state_d = BODY;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SOP;
            dest_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    cory_pipe #(.W(N)) u_z (
        .clk    (clk),
        .reset  (reset),
        .load_i (fwd),
        .d_i    (bus.a_d),
        .rdy_i  (bus.z_r),
        .v_o    (bus.z_v),
        .d_o    (bus.z_d)
    );

    cory_pipe #(.W(S)) u_s (
        .clk    (clk),
        .reset  (reset),
        .load_i (fwd),
        .d_i    (sel_now),
        .rdy_i  (bus.s_r),
        .v_o    (bus.s_v),
        .d_o    (bus.s_d)
    );

    assign o_err     = err_q;
    assign o_pkt_cnt = cnt_q;
endmodule
